// File: rtl/cs_seq_decoder_if.sv
// Local-bus chip-select sequencer port bundle: request side plus decoded select/strobe outputs.
// The master drives the request and device-ready; the slave (the sequencer) drives the rest.
interface cs_seq_decoder_if #(
  parameter int DEC_W = 3,
  parameter int N_CS  = 4
);
  logic             req;
  logic [DEC_W-1:0] addr_h;
  logic             dev_rdy;
  logic             busy;
  logic [N_CS-1:0]  cs_n;
  logic             strb_n;
  logic             ack;
  logic             err;

  modport master (
    output req, addr_h, dev_rdy,
    input  busy, cs_n, strb_n, ack, err
  );

  modport slave (
    input  req, addr_h, dev_rdy,
    output busy, cs_n, strb_n, ack, err
  );
endinterface

// File: rtl/cs_seq_decoder.sv
// Registered chip-select sequencer: decodes addr_h to one cs_n channel, then runs setup/strobe/hold.
// Optional CS_SEQ_DECODER_ERR_EN: unmapped addresses return an err pulse instead of a silent ack.
module cs_seq_decoder #(
  parameter int                    DEC_W     = 3,
  parameter int                    N_CS      = 4,
  parameter logic [N_CS*DEC_W-1:0] CS_MAP    = {3'b011, 3'b010, 3'b101, 3'b100},
  parameter int                    SETUP_CYC = 1,
  parameter int                    STRB_CYC  = 2,
  parameter int                    HOLD_CYC  = 1
) (
  input logic              clk,
  input logic              rst,
  cs_seq_decoder_if.slave  bus
);

  localparam int MAX_AB = (SETUP_CYC > STRB_CYC) ? SETUP_CYC : STRB_CYC;
  localparam int MAXC   = (MAX_AB > HOLD_CYC) ? MAX_AB : HOLD_CYC;
  localparam int CNT_W  = ($clog2(MAXC) < 1) ? 1 : $clog2(MAXC);

  localparam logic [CNT_W-1:0] SETUP_LD = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STRB_LD  = CNT_W'(STRB_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD  = CNT_W'(HOLD_CYC - 1);

  generate
    if (N_CS < 1 || N_CS > 16) begin : g_bad_ncs
      $error("cs_seq_decoder: N_CS must be 1..16");
    end
    if (SETUP_CYC < 1 || STRB_CYC < 1 || HOLD_CYC < 1) begin : g_bad_cyc
      $error("cs_seq_decoder: phase lengths must be at least 1");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_STROBE,
    S_HOLD,
    S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [N_CS-1:0]  sel_q, sel_d;
  logic [N_CS-1:0]  cs_n_q, cs_n_d;
  logic             strb_n_q, strb_n_d;
  logic             busy_q, busy_d;
  logic             ack_q, ack_d;

  logic [N_CS-1:0]  sel_dec;
  logic             hit;
  logic             active_d;

  // Scan from the top down so the lowest matching index is the one left standing.
  always_comb begin
    sel_dec = '0;
    hit     = 1'b0;
    for (int i = N_CS - 1; i >= 0; i--) begin
      if (bus.addr_h == CS_MAP[i*DEC_W +: DEC_W]) begin
        sel_dec    = '0;
        sel_dec[i] = 1'b1;
        hit        = 1'b1;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    sel_d   = sel_q;
    case (state_q)
      S_IDLE: begin
        if (bus.req) begin
          sel_d = sel_dec;
          if (hit) begin
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_DONE;
            cnt_d   = '0;
          end
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = STRB_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_STROBE: begin
        // Minimum strobe first, then dev_rdy low stretches it with the counter parked at 0.
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 1'b1;
        end else if (bus.dev_rdy) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // Outputs are precomputed from the next state so every pin leaves a flop.
  always_comb begin
    active_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    cs_n_d   = active_d ? ~sel_d : '1;
    strb_n_d = (state_d != S_STROBE);
    busy_d   = active_d;
    ack_d    = 1'b0;
  end

`ifdef CS_SEQ_DECODER_ERR_EN
  logic unm_q, unm_d;
  logic err_q, err_d;

  always_comb begin
    unm_d = unm_q;
    if (state_q == S_IDLE && bus.req) begin
      unm_d = ~hit;
    end
    err_d = (state_d == S_DONE) && unm_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      unm_q <= 1'b0;
      err_q <= 1'b0;
      ack_q <= 1'b0;
    end else begin
      unm_q <= unm_d;
      err_q <= err_d;
      ack_q <= (state_d == S_DONE) && !unm_d;
    end
  end

  assign bus.err = err_q;
`else
  always_ff @(posedge clk) begin
    if (rst) begin
      ack_q <= 1'b0;
    end else begin
      ack_q <= ack_d | (state_d == S_DONE);
    end
  end

  assign bus.err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      sel_q    <= '0;
      cs_n_q   <= '1;
      strb_n_q <= 1'b1;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sel_q    <= sel_d;
      cs_n_q   <= cs_n_d;
      strb_n_q <= strb_n_d;
      busy_q   <= busy_d;
    end
  end

  assign bus.cs_n   = cs_n_q;
  assign bus.strb_n = strb_n_q;
  assign bus.busy   = busy_q;
  assign bus.ack    = ack_q;

endmodule

// File: tb/tb_cs_seq_decoder.sv
// Directed bench for cs_seq_decoder: default-map DUT plus a second DUT with duplicated map entries.
// Per-access windows record cs_n/strb_n/busy/ack/err per cycle and compare against hand-computed counts.
module tb_cs_seq_decoder;
  logic clk = 1'b0;
  logic rst;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  cs_seq_decoder_if #(.DEC_W(3), .N_CS(4)) bus  ();
  cs_seq_decoder_if #(.DEC_W(3), .N_CS(4)) bus2 ();

  cs_seq_decoder u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  cs_seq_decoder #(
    .CS_MAP ({3'b011, 3'b110, 3'b110, 3'b100})
  ) u_dup (
    .clk (clk),
    .rst (rst),
    .bus (bus2)
  );

  assign bus2.addr_h  = bus.addr_h;
  assign bus2.dev_rdy = bus.dev_rdy;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One access: accept at edge T0, then observe cycles T0+1..T0+14.
  task automatic access(input string tag, input bit which, input logic [2:0] addr,
                        input int rdy_low, input int req_k, input int exp_bit,
                        input int exp_cs, input int exp_strb, input int exp_done,
                        input int exp_ack, input int exp_err, input bit chk_busy);
    int cs_cnt, oth_cnt, strb_cnt, busy_cnt, ack_cnt, err_cnt, done_cyc;
    logic [3:0] cs;
    cs_cnt = 0; oth_cnt = 0; strb_cnt = 0; busy_cnt = 0;
    ack_cnt = 0; err_cnt = 0; done_cyc = -1;
    bus.addr_h = addr;
    if (which) bus2.req = 1'b1; else bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0; bus2.req = 1'b0;
    bus.addr_h = ~addr;
    for (int k = 1; k <= 14; k++) begin
      bus.dev_rdy = !(k >= 3 && k < 3 + rdy_low);
      if (which) bus2.req = (k == req_k); else bus.req = (k == req_k);
      @(negedge clk);
      cs = which ? bus2.cs_n : bus.cs_n;
      for (int j = 0; j < 4; j++)
        if (!cs[j]) begin
          if (j == exp_bit) cs_cnt++; else oth_cnt++;
        end
      if (!(which ? bus2.strb_n : bus.strb_n)) strb_cnt++;
      if (which ? bus2.busy : bus.busy) busy_cnt++;
      if (which ? bus2.ack : bus.ack) ack_cnt++;
      if (which ? bus2.err : bus.err) err_cnt++;
      if (done_cyc < 0 && ((which ? bus2.ack : bus.ack) || (which ? bus2.err : bus.err)))
        done_cyc = k;
      @(posedge clk); #1;
    end
    bus.dev_rdy = 1'b1;
    bus.req = 1'b0; bus2.req = 1'b0;
    chk({tag, "_cs"}, cs_cnt, exp_cs);
    chk({tag, "_cs_other"}, oth_cnt, 0);
    chk({tag, "_strb"}, strb_cnt, exp_strb);
    chk({tag, "_done_cyc"}, done_cyc, exp_done);
    chk({tag, "_ack_cnt"}, ack_cnt, exp_ack);
    chk({tag, "_err_cnt"}, err_cnt, exp_err);
    if (chk_busy) chk({tag, "_busy"}, busy_cnt, exp_cs);
  endtask

  initial begin
    int ack_seen;
    rst = 1'b1;
    bus.req = 1'b1; bus2.req = 1'b0;
    bus.addr_h = 3'b100; bus.dev_rdy = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      @(negedge clk);
      chk("rst_cs_n", bus.cs_n, 4'b1111);
      chk("rst_strb_n", bus.strb_n, 1'b1);
      chk("rst_ack", bus.ack, 1'b0);
      chk("rst_busy", bus.busy, 1'b0);
      chk("rst_err", bus.err, 1'b0);
    end
    @(posedge clk); #1;
    rst = 1'b0; bus.req = 1'b0;
    @(posedge clk); #1;

    access("a100", 1'b0, 3'b100, 0, 0, 0, 4, 2, 5, 1, 0, 1'b1);
    access("a011", 1'b0, 3'b011, 0, 0, 3, 4, 2, 5, 1, 0, 1'b1);
    access("rdy_wait", 1'b0, 3'b101, 3, 0, 1, 7, 5, 8, 1, 0, 1'b1);
    access("req_ign", 1'b0, 3'b010, 0, 2, 2, 4, 2, 5, 1, 0, 1'b1);
`ifdef CS_SEQ_DECODER_ERR_EN
    access("unmapped", 1'b0, 3'b000, 0, 0, -1, 0, 0, 1, 0, 1, 1'b0);
`else
    access("unmapped", 1'b0, 3'b000, 0, 0, -1, 0, 0, 1, 1, 0, 1'b0);
`endif
    access("dup_map", 1'b1, 3'b110, 0, 0, 1, 4, 2, 5, 1, 0, 1'b1);

    // Reset during STROBE must release the bus with no ack.
    bus.addr_h = 3'b100; bus.req = 1'b1;
    @(posedge clk); #1;
    bus.req = 1'b0;
    @(posedge clk); #1;
    @(negedge clk);
    chk("mid_strb_active", bus.strb_n, 1'b0);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    @(negedge clk);
    chk("mid_rst_cs_n", bus.cs_n, 4'b1111);
    chk("mid_rst_strb_n", bus.strb_n, 1'b1);
    chk("mid_rst_busy", bus.busy, 1'b0);
    ack_seen = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      if (bus.ack) ack_seen++;
    end
    chk("mid_rst_no_ack", ack_seen, 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
